// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op codes and FSM state encoding
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MSUB  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - iterative restoring divider, one quotient bit per cycle
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             active_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] a_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    assign a_abs = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_abs = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One restoring step: shift next dividend bit in, keep the subtraction if it did not borrow
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Result is taken from the step that completes on the final edge, so done is combinational
    assign done = active_q && (cnt_q == CW'(1));

    // Sign fix-up and the two architecturally defined corner cases
    always_comb begin
        if (dz_q) begin
            quot = {WIDTH{1'b1}};
            rem  = a_q;
        end else if (ovf_q) begin
            quot = MIN_VAL;
            rem  = '0;
        end else begin
            quot = neg_q_q ? (~quo_n + 1'b1) : quo_n;
            rem  = neg_r_q ? (~rem_n + 1'b1) : rem_n;
        end
    end

    // Operand capture at load, then WIDTH iteration steps
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            a_q      <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            active_q <= 1'b1;
            cnt_q    <= CW'(WIDTH);
            rem_q    <= '0;
            quo_q    <= a_abs;
            dvs_q    <= b_abs;
            a_q      <= a;
            neg_q_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_q  <= is_signed && a[WIDTH-1];
            dz_q     <= (b == '0);
            ovf_q    <= is_signed && (a == MIN_VAL) && (b == {WIDTH{1'b1}});
        end else if (active_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/e_mdu_iter.sv
// rtl/e_mdu_iter.sv - E-stage multiply/divide unit with HI/LO registers
module e_mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int EN_MACC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXL = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
    localparam int CW   = $clog2(MAXL + 1);

    mdu_state_e         state_q;
    mdu_state_e         state_n;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         op_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;

    logic               op_is_mul;
    logic               op_is_div;
    logic               acc_mul;
    logic               acc_div;
    logic               wr_hi;
    logic               wr_lo;
    logic               fin_mul;
    logic               fin_div;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;
    logic [2*WIDTH-1:0] mul_res;
    logic               div_done;
    logic [WIDTH-1:0]   div_quot;
    logic [WIDTH-1:0]   div_rem;

    assign op_is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU) ||
                       ((EN_MACC != 0) && ((mdu_op == MDU_MADD) || (mdu_op == MDU_MSUB)));
    assign op_is_div = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);

    // Sign-extending to 2W makes the low 2W bits of the product the signed product
    assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Accumulate into the HI/LO value present at the final edge
    always_comb begin
        unique case (op_q)
            MDU_MADD: mul_res = {hi_q, lo_q} + prod_q;
            MDU_MSUB: mul_res = {hi_q, lo_q} - prod_q;
            default:  mul_res = prod_q;
        endcase
    end

    mdu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (acc_div),
        .is_signed (mdu_op == MDU_DIV),
        .a         (a),
        .b         (b),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    // Next state and per-edge strobes; inputs are only looked at while idle
    always_comb begin
        state_n = state_q;
        acc_mul = 1'b0;
        acc_div = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        fin_mul = 1'b0;
        fin_div = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!req) begin
                    if (start && op_is_mul) begin
                        acc_mul = 1'b1;
                        state_n = S_MUL;
                    end else if (start && op_is_div) begin
                        acc_div = 1'b1;
                        state_n = S_DIV;
                    end else if (!start && (mdu_op == MDU_MTHI)) begin
                        wr_hi = 1'b1;
                    end else if (!start && (mdu_op == MDU_MTLO)) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(1)) begin
                    fin_mul = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    fin_div = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, latency counter, product capture and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_n;
            busy_q  <= (state_n != S_IDLE);
            if (acc_mul) begin
                cnt_q  <= CW'(MULT_LAT);
                op_q   <= mdu_op;
                prod_q <= (mdu_op == MDU_MULTU) ? uprod : sprod;
            end else if (acc_div) begin
                cnt_q <= CW'(WIDTH);
                op_q  <= mdu_op;
            end else if ((state_q != S_IDLE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (wr_hi) begin
                hi_q <= a;
            end
            if (wr_lo) begin
                lo_q <= a;
            end
            if (fin_mul) begin
                {hi_q, lo_q} <= mul_res;
            end
            if (fin_div) begin
                hi_q <= div_rem;
                lo_q <= div_quot;
            end
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
